// File: rtl/mem_writer_pkg.sv
// mem_writer_pkg: definitions shared by the RAM write controller and the
// memory display path.
//   - default RAM geometry (address/data widths, depth)
//   - 2-bit controller state encoding
//   - write mode (single word / whole-RAM fill)
package mem_writer_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } mw_state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_FILL   = 1'b1
  } mw_mode_t;

endpackage

// File: rtl/mem_writer.sv
// mem_writer: write-side controller for the board RAM.
// Writes one word (wr_req) or fills the whole RAM (fill_req), reads every
// written word back and keeps a sticky mismatch flag with the first failing
// address.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_req, fill_req    one-cycle request pulses (ignored while busy)
//   clr_err             level, clears err/err_addr
//   din                 switch data
//   ram_dout            RAM read data
//   ram_we/addr/din     RAM write port (all registered)
//   cur_addr            next single-write address (to display)
//   busy, done          status; done pulses once on return to IDLE
//   err, err_addr       sticky readback mismatch and its first address
//
// state  | meaning
// IDLE   | waiting for a request, ram_addr follows cur_addr
// WRITE  | ram_we high for the current location
// SETTLE | address held so a registered RAM read can complete
// CHECK  | compare readback, then advance / finish
module mem_writer
  import mem_writer_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FILL_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              fill_req,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  mw_state_t         state;
  mw_mode_t          mode;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic [ADDR_W-1:0] waddr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              mismatch;

  assign waddr_next = waddr + ADDR_W'(1);
  assign wdata_next = wdata + DATA_W'(FILL_INC);
  assign mismatch   = (ram_dout != wdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode     <= MODE_SINGLE;
      waddr    <= '0;
      wdata    <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      cur_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      done   <= 1'b0;
      ram_we <= 1'b0;

      // A mismatch in CHECK below overrides this clear in the same cycle.
      if (clr_err) begin
        err      <= 1'b0;
        err_addr <= '0;
      end

      case (state)
        ST_IDLE: begin
          ram_addr <= cur_addr;
          if (fill_req) begin
            mode     <= MODE_FILL;
            waddr    <= '0;
            wdata    <= din;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= din;
            busy     <= 1'b1;
            state    <= ST_WRITE;
          end else if (wr_req) begin
            mode     <= MODE_SINGLE;
            waddr    <= cur_addr;
            wdata    <= din;
            ram_we   <= 1'b1;
            ram_addr <= cur_addr;
            ram_din  <= din;
            busy     <= 1'b1;
            state    <= ST_WRITE;
          end
        end

        ST_WRITE:  state <= ST_SETTLE;

        ST_SETTLE: state <= ST_CHECK;

        ST_CHECK: begin
          // Only the first failure since the last clear is recorded.
          if (mismatch && (!err || clr_err)) begin
            err      <= 1'b1;
            err_addr <= waddr;
          end
          if (mode == MODE_SINGLE) begin
            cur_addr <= waddr_next;
            ram_addr <= waddr_next;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else if (waddr != {ADDR_W{1'b1}}) begin
            waddr    <= waddr_next;
            wdata    <= wdata_next;
            ram_we   <= 1'b1;
            ram_addr <= waddr_next;
            ram_din  <= wdata_next;
            state    <= ST_WRITE;
          end else begin
            cur_addr <= '0;
            ram_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
